dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit data memory (256 x 8, combinational read, write on posedge CLK) between NUM_REQ requesters, e.g. processor core and a block-copy/loader engine.
- One memory access per cycle; round-robin selection with an optional bounded lock for atomic multi-cycle sequences.
- Sits between the requesters and the data memory; drives its address, write data and write-enable, and returns registered read data.

Parameters:
- NUM_REQ, 2, number of requester ports (2..4).
- MAX_LOCK, 8, maximum consecutive locked grants before forced release (1..255).

Ports:
- CLK  input  1  clock.
- RST_N  input  1  reset; synchronous, active-low (sampled on posedge CLK).
- req  input  NUM_REQ  per-port access request.
- lock  input  NUM_REQ  per-port lock request; meaningful only together with req.
- we  input  NUM_REQ  per-port write (1) / read (0).
- addr  input  NUM_REQ*8  per-port address; port i at [8i+7:8i].
- wdata  input  NUM_REQ*8  per-port write data; same packing as addr.
- gnt  output  NUM_REQ  one-hot grant, combinational, valid in the request cycle.
- rvalid  output  NUM_REQ  one-hot read-data-valid, registered.
- rdata  output  8  read data for the port flagged by rvalid.
- mem_addr  output  8  to memory addr_in.
- mem_wdata  output  8  to memory data_in.
- mem_we  output  1  to memory writemem_ctrl.
- mem_rdata  input  8  from memory data_out.

Behaviour:
- Reset (RST_N=0 at posedge): state=IDLE, last_q=NUM_REQ-1 (port 0 has first priority), lock_cnt=0, rvalid=0, rdata=0. While RST_N=0: gnt=0, mem_we=0, mem_addr=0, mem_wdata=0. A lock in progress is abandoned.
- Request rules: a requester holds req/we/addr/wdata (and lock) stable until it sees gnt. It may change them or drop req in the cycle after gnt.
- Arbitration (IDLE), cycle N: the winner is the first asserted req scanning last_q+1, last_q+2, ... modulo NUM_REQ. gnt[winner]=1 and the mem_* outputs carry the winner's addr/wdata/we. At the posedge ending cycle N, last_q is updated to the winner.
- No req in cycle N: gnt=0, mem_we=0, mem_addr=0, mem_wdata=0; last_q is unchanged.
- Write: committed at the posedge ending cycle N; rvalid stays 0.
- Read: mem_rdata is captured into rdata at the posedge ending cycle N. rvalid[winner]=1 in cycle N+1 only. rdata holds its value afterwards, but it is valid only while rvalid is asserted.
- Back-to-back: a new grant is possible every cycle, so read latency is 1 cycle at full throughput. A write followed by a read to the same address in the next cycle returns the new data.
- Lock: if the winner has lock=1, go to LOCKED(owner=winner) with lock_cnt=1.
- LOCKED: while req[owner]&lock[owner]=1 and lock_cnt<MAX_LOCK, grant owner only and increment lock_cnt. Other ports wait, with gnt=0 for them.
- Lock release:
  - When req[owner] or lock[owner] drops, return to IDLE and arbitrate in that same cycle.
  - When lock_cnt reaches MAX_LOCK, force a return to IDLE with last_q=owner, so other requesters win next. The owner may relock later through normal arbitration.
- lock_cnt is 8 bits and saturates; it is cleared on entry to IDLE.
- gnt is always one-hot or zero; rvalid is always one-hot or zero.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority, lowest index wins, and last_q is unused. The lock and MAX_LOCK behaviour is unchanged; a forced release gives one cycle in which the owner is excluded from arbitration.
- Undefined: round-robin as specified above.

Decomposition:
- Package dmem_pkg: ADDR_W=8, DATA_W=8, MEM_DEPTH=256, typedef enum logic {IDLE, LOCKED} arb_state_t, LOCK_CNT_W=8.
- Sub-module rr_pick: purely combinational. Inputs are the req vector, last index and exclude mask; output is the one-hot winner. The fixed-priority variant is selected inside it under DMEM_ARB_FIXED_PRIO_EN.
- Top module holds the FSM, lock counter, pointer and read-data register.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with req=2'b11 -> gnt=0, mem_we=0, rvalid=0; on the first cycle after release, gnt=2'b01.
- Contention: req=2'b11 for 4 cycles, both reading 0x10/0x20 -> gnt sequence 01,10,01,10; rvalid follows one cycle later with mem[0x10]/mem[0x20].
- Write-then-read: port1 writes 0x5A to 0x2B, next cycle reads 0x2B -> one cycle after the read grant, rvalid=2'b10 and rdata=0x5A.
- Lock: port0 holds req+lock with req1=1 and MAX_LOCK=3 -> gnt0 for 3 cycles, then gnt1 in cycle 4; lock_cnt cleared.
- Reset mid-lock: assert RST_N=0 during cycle 2 of a lock -> IDLE, gnt=0; after release, port 0 wins again as it has first priority.
- DMEM_ARB_FIXED_PRIO_EN defined, req=2'b11 held -> gnt=01 every cycle; with the lock forced release, gnt1 gets exactly one cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The optional feature DMEM_ARB_FIXED_PRIO_EN is consumed by dmem_arbiter and dmem_arbiter_rr_pick.
package dmem_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned MEM_DEPTH  = 256;
  localparam int unsigned LOCK_CNT_W = 8;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational winner selection: round-robin after 'last', or fixed lowest-index priority
// when DMEM_ARB_FIXED_PRIO_EN is defined. Ports in 'excl' never win.
module dmem_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    last,
  input  logic [NUM_REQ-1:0] excl,
  output logic [NUM_REQ-1:0] win
);

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] one;

  assign cand = req & ~excl;
  assign one  = {{(NUM_REQ-1){1'b0}}, 1'b1};

`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
  // Isolate the lowest set bit.
  assign win = cand & (~cand + one);
`else
  logic [IdxW:0]        shamt;
  logic [2*NUM_REQ-1:0] rot_wide;
  logic [2*NUM_REQ-1:0] unrot_wide;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   pri;

  always_comb begin
    if (last == IdxW'(NUM_REQ - 1)) begin
      shamt = '0;
    end else begin
      shamt = {1'b0, last} + {{IdxW{1'b0}}, 1'b1};
    end
  end

  // Rotate so the port after 'last' sits at bit 0, take the first set bit, rotate back.
  assign rot_wide   = {cand, cand} >> shamt;
  assign rot        = rot_wide[NUM_REQ-1:0];
  assign pri        = rot & (~rot + one);
  assign unrot_wide = {pri, pri} << shamt;
  assign win        = unrot_wide[2*NUM_REQ-1:NUM_REQ];
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter with round-robin grant, bounded lock and registered read data.
// Define DMEM_ARB_FIXED_PRIO_EN to use fixed lowest-index priority instead of round-robin.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_we,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LOCK_CNT_W-1:0] LockMax = LOCK_CNT_W'(MAX_LOCK);

  arb_state_t            state_q, state_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [NUM_REQ-1:0] win, excl, owner_oh;
  logic [IdxW-1:0]    win_idx;

  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Forced release keeps the owner out of arbitration for one cycle.
  assign excl = (state_q == LOCKED && lock_cnt_q >= LockMax) ? owner_oh : '0;
`else
  assign excl = '0;
`endif

  dmem_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .excl (excl),
    .win  (win)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = IdxW'(i);
    end
  end

  always_comb begin
    logic arb_en;
    arb_en     = 1'b0;
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    gnt        = '0;

    unique case (state_q)
      IDLE: arb_en = 1'b1;
      LOCKED: begin
        if (req[owner_q] && lock[owner_q] && lock_cnt_q < LockMax) begin
          gnt        = owner_oh;
          lock_cnt_d = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + 1'b1;
        end else begin
          // last_q already equals the owner, so round-robin favours the others.
          arb_en = 1'b1;
        end
      end
      default: arb_en = 1'b1;
    endcase

    if (arb_en) begin
      gnt        = win;
      state_d    = IDLE;
      lock_cnt_d = '0;
      if (|win) begin
        last_d = win_idx;
        if (|(win & lock)) begin
          state_d    = LOCKED;
          owner_d    = win_idx;
          lock_cnt_d = {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end

    if (!RST_N) gnt = '0;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      mem_addr  = mem_addr  | (addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{gnt[i]}});
      mem_wdata = mem_wdata | (wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
      mem_we    = mem_we    | (we[i] & gnt[i]);
    end
  end

  assign rvalid_d = gnt & ~we;
  assign rdata_d  = (|rvalid_d) ? mem_rdata : rdata_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      last_q     <= IdxW'(NUM_REQ - 1);
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter (NUM_REQ=2, MAX_LOCK=3) with a queue scoreboard.
// Under DMEM_ARB_FIXED_PRIO_EN a fixed-priority vector set is used instead.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  req, lock, we, gnt, rvalid;
  logic [15:0] addr, wdata;
  logic [7:0]  rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [7:0]  mem [256];

  typedef struct {
    logic [1:0] g;
    logic [1:0] rv;
    logic       w;
    logic [7:0] ad;
    logic [7:0] wd;
  } cyc_t;

  cyc_t       cq[$];
  logic [7:0] dq[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  dmem_arbiter #(
    .NUM_REQ  (2),
    .MAX_LOCK (3)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs after the edge and queue what this cycle must show.
  task automatic step(input logic rst, input logic [1:0] rq, input logic [1:0] lk,
                      input logic [1:0] w, input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] eg,
                      input logic [1:0] erv, input logic [7:0] ed);
    cyc_t c;
    @(posedge CLK);
    #1;
    RST_N = rst;
    req   = rq;
    lock  = lk;
    we    = w;
    addr  = {a1, a0};
    wdata = {d1, d0};
    c.g   = eg;
    c.rv  = erv;
    c.w   = |(eg & w);
    c.ad  = eg[0] ? a0 : (eg[1] ? a1 : 8'h00);
    c.wd  = eg[0] ? d0 : (eg[1] ? d1 : 8'h00);
    cq.push_back(c);
    if (erv != 2'b00) dq.push_back(ed);
  endtask

  // Monitor: compares whatever the DUT presents each cycle against the queued expectations.
  initial begin
    cyc_t c;
    forever begin
      @(negedge CLK);
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("gnt", {6'd0, gnt}, {6'd0, c.g});
        chk("rvalid", {6'd0, rvalid}, {6'd0, c.rv});
        chk("mem_we", {7'd0, mem_we}, {7'd0, c.w});
        chk("mem_addr", mem_addr, c.ad);
        chk("mem_wdata", mem_wdata, c.wd);
      end
      if (rvalid != 2'b00) begin
        if (dq.size() > 0) chk("rdata", rdata, dq.pop_front());
        else chk("rdata_unexpected", {6'd0, rvalid}, 8'h00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
    RST_N = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    step(0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00);
    step(0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00);
    step(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    step(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b01, 8'h2C);
    // Lock with forced release: port 1 gets exactly one slot.
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b01, 8'h2C);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b01, 8'h2C);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b01, 8'h2C);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 2'b01, 8'h2C);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b10, 8'h1C);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b01, 8'h2C);
    step(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h2C);
`else
    // Reset held with both requesting.
    step(0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00);
    step(0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00);
    // Contention: alternating grants, reads return one cycle later.
    step(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    step(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 2'b01, 8'h2C);
    step(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b10, 8'h1C);
    step(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 2'b01, 8'h2C);
    step(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h1C);
    // Port 1 writes 0x5A to 0x2B, then reads it back.
    step(1, 2'b10, 2'b00, 2'b10, 8'h00, 8'h2B, 8'h00, 8'h5A, 2'b10, 2'b00, 8'h00);
    step(1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h2B, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00);
    step(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b10, 8'h5A);
    // Port 0 locks; forced release after three grants hands cycle 4 to port 1.
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b01, 8'h2C);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b01, 8'h2C);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 2'b01, 8'h2C);
    // Port 0 relocks, then reset lands in the second locked cycle.
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b10, 8'h1C);
    step(1, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b01, 8'h2C);
    step(0, 2'b11, 2'b01, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b00, 2'b01, 8'h2C);
    step(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00);
    step(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h2C);
    // Owner drops lock: arbitration happens in that same cycle.
    step(1, 2'b11, 2'b10, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00);
    step(1, 2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01, 2'b10, 8'h1C);
    step(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b01, 8'h2C);
`endif
    step(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00);
    repeat (3) @(posedge CLK);
    chk("pending_reads", 8'(dq.size()), 8'h00);
    chk("pending_cycles", 8'(cq.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
